// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit.
// Moves the operand at most STEP bit positions per clock. A start/done
// handshake lets the controlling FSM stall until the result is valid.
// mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Any other value
// passes the operand through unchanged, with the same timing.
module seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // STEP and WIDTH can both equal 2**SHAMT_W, so they need one extra bit.
  localparam int             STEP_I  = STEP;
  localparam int             WIDTH_I = WIDTH;
  localparam logic [SHAMT_W:0] STEP_C  = STEP_I[SHAMT_W:0];
  localparam logic [SHAMT_W:0] WIDTH_C = WIDTH_I[SHAMT_W:0];

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               zero_reg, zero_next;
  logic [SHAMT_W-1:0] rem_reg, rem_next;
  logic [2:0]         mode_reg, mode_next;
  logic               sign_reg, sign_next;

  logic               accept;
  logic               rem_lt_step;
  logic [SHAMT_W-1:0] step_n;
  logic [SHAMT_W:0]   wrap_n;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   step_result;
  logic [SHAMT_W-1:0] rem_step;

  // A request is taken in any state other than SHIFT, including DONE (back-to-back).
  assign accept = start && (state_reg != SHIFT);

  // One partial shift of n = min(STEP, rem) positions on the held result.
  always_comb begin
    rem_lt_step = ({1'b0, rem_reg} < STEP_C);
    // When STEP == WIDTH the low bits of STEP_C are zero, but then rem < STEP
    // always holds, so that branch is never taken.
    step_n      = rem_lt_step ? rem_reg : STEP_C[SHAMT_W-1:0];
    wrap_n      = WIDTH_C - {1'b0, step_n};
    fill_mask   = ~({WIDTH{1'b1}} >> step_n);
    rem_step    = rem_reg - step_n;
    case (mode_reg)
      MODE_SLL: step_result = result_reg << step_n;
      MODE_SRL: step_result = result_reg >> step_n;
      // The sign captured at accept is used, not the current MSB.
      MODE_SRA: step_result = (result_reg >> step_n) | (sign_reg ? fill_mask : '0);
      // A wrap amount of WIDTH (n = 0) shifts everything out, giving a no-op rotate.
      MODE_ROL: step_result = (result_reg << step_n) | (result_reg >> wrap_n);
      MODE_ROR: step_result = (result_reg >> step_n) | (result_reg << wrap_n);
      default:  step_result = result_reg;
    endcase
  end

  // Datapath next values: load on accept, step while shifting, otherwise hold.
  always_comb begin
    result_next = result_reg;
    rem_next    = rem_reg;
    mode_next   = mode_reg;
    sign_next   = sign_reg;
    if (accept) begin
      result_next = operand;
      rem_next    = shamt;
      mode_next   = mode;
      sign_next   = operand[WIDTH-1];
    end else if (state_reg == SHIFT) begin
      result_next = step_result;
      rem_next    = rem_step;
    end
    zero_next = (result_next == '0);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers. Reset leaves a zero result with the zero flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      zero_reg   <= 1'b1;
      rem_reg    <= '0;
      mode_reg   <= '0;
      sign_reg   <= 1'b0;
    end else begin
      result_reg <= result_next;
      zero_reg   <= zero_next;
      rem_reg    <= rem_next;
      mode_reg   <= mode_next;
      sign_reg   <= sign_next;
    end
  end

  // Next-state logic. A zero shift amount skips SHIFT and goes straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (shamt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (rem_step == '0) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = (shamt != '0) ? SHIFT : DONE;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the registered state and datapath only.
  always_comb begin
    busy   = (state_reg == SHIFT);
    ready  = (state_reg != SHIFT);
    done   = (state_reg == DONE);
    result = result_reg;
    zero   = zero_reg;
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: self-checking bench for seq_shifter.
// Instance 0 uses STEP=1 and instance 1 uses STEP=4, both with WIDTH=8.
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       start_a   [2];
  logic [2:0] mode_a    [2];
  logic [2:0] shamt_a   [2];
  logic [7:0] operand_a [2];
  logic       ready_a   [2];
  logic       busy_a    [2];
  logic       done_a    [2];
  logic [7:0] result_a  [2];
  logic       zero_a    [2];

  int n_checks = 0;
  int n_fail   = 0;

  seq_shifter #(.WIDTH(8), .STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .mode(mode_a[0]),
    .shamt(shamt_a[0]), .operand(operand_a[0]), .ready(ready_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .result(result_a[0]), .zero(zero_a[0])
  );

  seq_shifter #(.WIDTH(8), .STEP(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .mode(mode_a[1]),
    .shamt(shamt_a[1]), .operand(operand_a[1]), .ready(ready_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .result(result_a[1]), .zero(zero_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [2:0] m;
    int         sh;
    logic [7:0] op;
    logic [7:0] exp;
    logic       expz;
  } vec_t;

  vec_t vecs[13];

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference result built bit by bit from the mode definitions.
  function automatic logic [7:0] ref_shift(input logic [2:0] m, input int sh, input logic [7:0] op);
    logic [7:0] r;
    r = op;
    case (m)
      3'd0: r = op << sh;
      3'd1: r = op >> sh;
      3'd2: for (int i = 0; i < 8; i++) r[i] = (i + sh < 8) ? op[i + sh] : op[7];
      3'd3: for (int i = 0; i < 8; i++) r[(i + sh) % 8] = op[i];
      3'd4: for (int i = 0; i < 8; i++) r[i] = op[(i + sh) % 8];
      default: r = op;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample just after each edge until done rises or the cycle budget runs out.
  task automatic wait_done(input int d, input int first_edges, output int edges, output int busy_cnt);
    edges    = first_edges;
    busy_cnt = 0;
    while (!done_a[d] && edges < 40) begin
      if (busy_a[d]) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    if (!done_a[d]) check("done_timeout", 32'(done_a[d]), 32'd1);
  endtask

  // Issue one request and collect its result and timing. Ends one cycle after done.
  task automatic run_op(input int d, input logic [2:0] m, input int sh, input logic [7:0] op,
                        output logic [7:0] res, output logic z, output int edges, output int busy_cnt);
    start_a[d]   = 1'b1;
    mode_a[d]    = m;
    shamt_a[d]   = 3'(sh);
    operand_a[d] = op;
    @(posedge clk); #1;
    start_a[d] = 1'b0;
    wait_done(d, 0, edges, busy_cnt);
    res = result_a[d];
    z   = zero_a[d];
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_a[d]), 32'd0);
    check("result_held", 32'(result_a[d]), 32'(res));
  endtask

  initial begin
    logic [7:0] res;
    logic       z;
    int         edges;
    int         bcnt;
    int         nsteps;
    int         seen_done;

    vecs[0]  = '{0, 3'd0, 3, 8'h05, 8'h28, 1'b0};
    vecs[1]  = '{0, 3'd2, 2, 8'h90, 8'hE4, 1'b0};
    vecs[2]  = '{0, 3'd1, 2, 8'h90, 8'h24, 1'b0};
    vecs[3]  = '{0, 3'd4, 1, 8'h81, 8'hC0, 1'b0};
    vecs[4]  = '{0, 3'd3, 1, 8'h81, 8'h03, 1'b0};
    vecs[5]  = '{0, 3'd0, 0, 8'hA5, 8'hA5, 1'b0};
    vecs[6]  = '{0, 3'd2, 0, 8'hA5, 8'hA5, 1'b0};
    vecs[7]  = '{1, 3'd1, 7, 8'hF0, 8'h01, 1'b0};
    vecs[8]  = '{1, 3'd1, 4, 8'hF0, 8'h0F, 1'b0};
    vecs[9]  = '{0, 3'd0, 1, 8'h80, 8'h00, 1'b1};
    vecs[10] = '{0, 3'd7, 5, 8'hA5, 8'hA5, 1'b0};
    vecs[11] = '{1, 3'd3, 5, 8'h81, 8'h30, 1'b0};
    vecs[12] = '{1, 3'd2, 6, 8'h80, 8'hFE, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0; mode_a[d] = 3'd0; shamt_a[d] = 3'd0; operand_a[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready",  32'(ready_a[d]),  32'd1);
      check("reset_busy",   32'(busy_a[d]),   32'd0);
      check("reset_done",   32'(done_a[d]),   32'd0);
      check("reset_result", 32'(result_a[d]), 32'd0);
      check("reset_zero",   32'(zero_a[d]),   32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with constant expected values.
    for (int i = 0; i < 13; i++) begin
      nsteps = (vecs[i].sh + step_of(vecs[i].d) - 1) / step_of(vecs[i].d);
      run_op(vecs[i].d, vecs[i].m, vecs[i].sh, vecs[i].op, res, z, edges, bcnt);
      $display("vec %0d: dut%0d mode=%0d sh=%0d op=%02h -> result=%02h zero=%0b edges=%0d",
               i, vecs[i].d, vecs[i].m, vecs[i].sh, vecs[i].op, res, z, edges);
      check("vec_result", 32'(res),   32'(vecs[i].exp));
      check("vec_zero",   32'(z),     32'(vecs[i].expz));
      check("vec_edges",  32'(edges), 32'(nsteps));
      check("vec_busy",   32'(bcnt),  32'(nsteps));
    end

    // Start while busy is ignored: SLL 8'h03 by 5, second start at cycle 2.
    start_a[0] = 1'b1; mode_a[0] = 3'd0; shamt_a[0] = 3'd5; operand_a[0] = 8'h03;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    @(posedge clk); #1;
    start_a[0] = 1'b1; mode_a[0] = 3'd1; shamt_a[0] = 3'd1; operand_a[0] = 8'hFF;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    check("busy_ignore_busy", 32'(busy_a[0]), 32'd1);
    wait_done(0, 2, edges, bcnt);
    $display("ignore-while-busy: result=%02h edges=%0d", result_a[0], edges);
    check("busy_ignore_result", 32'(result_a[0]), 32'h60);
    check("busy_ignore_edges",  32'(edges),       32'd5);
    @(posedge clk); #1;
    check("busy_ignore_idle", 32'(ready_a[0]), 32'd1);

    // Back-to-back: second request accepted in the DONE cycle.
    start_a[0] = 1'b1; mode_a[0] = 3'd0; shamt_a[0] = 3'd3; operand_a[0] = 8'h05;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    wait_done(0, 0, edges, bcnt);
    check("b2b_first_result", 32'(result_a[0]), 32'h28);
    start_a[0] = 1'b1; mode_a[0] = 3'd1; shamt_a[0] = 3'd2; operand_a[0] = 8'h90;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    check("b2b_accepted_busy", 32'(busy_a[0]), 32'd1);
    wait_done(0, 0, edges, bcnt);
    $display("back-to-back: result=%02h edges=%0d", result_a[0], edges);
    check("b2b_second_result", 32'(result_a[0]), 32'h24);
    check("b2b_second_edges",  32'(edges),       32'd2);
    @(posedge clk); #1;

    // Reset asserted mid-SHIFT abandons the operation without a done pulse.
    start_a[0] = 1'b1; mode_a[0] = 3'd0; shamt_a[0] = 3'd7; operand_a[0] = 8'h05;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy_before", 32'(busy_a[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", 32'(result_a[0]), 32'd0);
    check("rst_mid_zero",   32'(zero_a[0]),   32'd1);
    check("rst_mid_busy",   32'(busy_a[0]),   32'd0);
    check("rst_mid_ready",  32'(ready_a[0]),  32'd1);
    check("rst_mid_done",   32'(done_a[0]),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_a[0]) seen_done++;
    end
    $display("reset mid-shift: result=%02h done_seen=%0d", result_a[0], seen_done);
    check("rst_mid_no_done", 32'(seen_done), 32'd0);
    check("rst_mid_result_after", 32'(result_a[0]), 32'd0);

    // Random requests checked against the reference model.
    for (int i = 0; i < 300; i++) begin
      int         d;
      logic [2:0] m;
      int         sh;
      logic [7:0] op;
      logic [7:0] exp;
      d  = int'($urandom_range(0, 1));
      m  = 3'($urandom_range(0, 7));
      sh = int'($urandom_range(0, 7));
      op = 8'($urandom);
      exp = ref_shift(m, sh, op);
      nsteps = (sh + step_of(d) - 1) / step_of(d);
      run_op(d, m, sh, op, res, z, edges, bcnt);
      $display("rand %0d: dut%0d mode=%0d sh=%0d op=%02h -> result=%02h (model %02h) edges=%0d",
               i, d, m, sh, op, res, exp, edges);
      check("rand_result", 32'(res),   32'(exp));
      check("rand_zero",   32'(z),     32'(exp == 8'h00));
      check("rand_edges",  32'(edges), 32'(nsteps));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
